lcd_spi_rx: RTL and testbench

SPI responder that receives the byte stream the LCD driver emits (SCK, MOSI, DC, CS) and presents each byte, tagged with its DC (command/data) bit, on a valid/ready stream. It sits on the display side of the link: as an on-FPGA display model for loopback testing of the LCD path, and as the front end of any SPI-attached peripheral the team builds. All SPI inputs are asynchronous to `clk` and are synchronized internally.

---
 rtl/lcd_spi_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/lcd_spi_rx.sv | 175 +++++++++++++++++
 tb/tb_lcd_spi_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_spi_pkg.sv
// -----------------------------------------------------------------------------
// lcd_spi_pkg
// Definitions shared by the LCD SPI transmit and receive sides.
//   BYTE_W      : width of one SPI byte
//   lcd_state_e : serial FSM states (IDLE, SHIFT)
//   rx_entry_t  : one buffered byte with its DC (command/data) tag
// -----------------------------------------------------------------------------
package lcd_spi_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } lcd_state_e;

   typedef struct packed {
      logic              dc;
      logic [BYTE_W-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered read/write pointers and an occupancy
// counter. The head entry is presented combinationally from the storage
// array at the read pointer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : write wr_data; accepted when not full, or when full and a
//               pop is accepted in the same cycle
//   wr_data   : entry to write
//   pop       : remove head entry; ignored when empty
//   rd_data   : head entry (undefined content when empty)
//   full      : FIFO holds DEPTH entries
//   empty     : FIFO holds no entries
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok = push & (~full | pop_ok);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset so it can map onto RAM; validity comes from count_q.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/lcd_spi_rx.sv
// -----------------------------------------------------------------------------
// lcd_spi_rx
// SPI mode-0 responder for the LCD link. Receives MSB-first bytes under an
// active-low chip select, tags each byte with the DC level seen on its last
// bit, and queues it for a valid/ready consumer.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   spi_clk    : SCK from master (asynchronous, idle low, sampled on rise)
//   spi_mosi   : serial data, MSB first (asynchronous)
//   spi_dc     : 0 = command, 1 = data; captured with bit 0 (asynchronous)
//   spi_cs     : chip select, active low (asynchronous)
//   rx_data    : head byte, 0 when empty
//   rx_dc      : head DC tag, 0 when empty
//   rx_valid   : buffer non-empty
//   rx_ready   : consumer takes head byte when rx_valid & rx_ready
//   overflow   : sticky, a completed byte was dropped on a full buffer
//   frame_err  : one-cycle pulse, CS released with a partial byte
//   busy       : CS asserted and FSM shifting
// -----------------------------------------------------------------------------
module lcd_spi_rx
   import lcd_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_dc,
   input  logic       spi_cs,
   output logic [7:0] rx_data,
   output logic       rx_dc,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overflow,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [0:0] ST_IDLE  = IDLE;
   localparam logic [0:0] ST_SHIFT = SHIFT;

   // ---------------- input synchronizers + edge-detect flops ----------------
   logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] dc_sync_q,   dc_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic                   sck_dly_q,   sck_dly_d;
   logic                   cs_dly_q,    cs_dly_d;

   logic sck_s, mosi_s, dc_s, cs_s;
   logic sck_rise, cs_fall, cs_rise;

   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  spi_clk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0],   spi_dc};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs};
      sck_dly_d   = sck_s;
      cs_dly_d    = cs_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         dc_sync_q   <= '0;
         // CS path resets to the deasserted level so reset release is not a CS edge.
         cs_sync_q   <= '1;
         sck_dly_q   <= 1'b0;
         cs_dly_q    <= 1'b1;
      end else begin
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         dc_sync_q   <= dc_sync_d;
         cs_sync_q   <= cs_sync_d;
         sck_dly_q   <= sck_dly_d;
         cs_dly_q    <= cs_dly_d;
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign dc_s     = dc_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_dly_q;
   assign cs_fall  = ~cs_s & cs_dly_q;
   assign cs_rise  = cs_s & ~cs_dly_q;

   // ---------------- serial FSM ----------------
   logic [0:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic              frame_err_q, frame_err_d;
   logic              overflow_q, overflow_d;
   logic              push_req;
   rx_entry_t         push_entry;
   rx_entry_t         head_entry;
   logic              fifo_full, fifo_empty, fifo_pop;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      shift_d         = shift_q;
      frame_err_d     = 1'b0;
      push_req        = 1'b0;
      push_entry.dc   = dc_s;
      push_entry.data = {shift_q[BYTE_W-2:0], mosi_s};
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (cs_fall) begin
               state_d = ST_SHIFT;
            end
         end
         default: begin
            if (sck_rise) begin
               shift_d  = {shift_q[BYTE_W-2:0], mosi_s};
               cnt_d    = cnt_q + 3'd1;
               push_req = (cnt_q == 3'd7);
            end
            // CS release is judged after any coincident SCK edge has been
            // counted, so a byte finishing on the same cycle is not an error.
            if (cs_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = (cnt_d != 3'd0);
               cnt_d       = '0;
            end
         end
      endcase
   end

   assign fifo_pop   = rx_ready & ~fifo_empty;
   assign overflow_d = overflow_q | (push_req & fifo_full & ~fifo_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   // ---------------- receive buffer ----------------
   sync_fifo #(
      .WIDTH ($bits(rx_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_req),
      .wr_data (push_entry),
      .pop     (fifo_pop),
      .rd_data (head_entry),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rx_valid  = ~fifo_empty;
   assign rx_data   = fifo_empty ? 8'h00 : head_entry.data;
   assign rx_dc     = fifo_empty ? 1'b0  : head_entry.dc;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q == ST_SHIFT) & ~cs_s;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_lcd_spi_rx
// Directed bench for lcd_spi_rx: bytes are clocked in through SCK/MOSI/DC/CS
// with the minimum-safe SCK phase of 4 clk cycles. Bytes popped by the DUT
// are recorded by a monitor and compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_lcd_spi_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_clk;
   logic       spi_mosi;
   logic       spi_dc;
   logic       spi_cs;
   logic [7:0] rx_data;
   logic       rx_dc;
   logic       rx_valid;
   logic       rx_ready;
   logic       overflow;
   logic       frame_err;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int ferr_cnt = 0;
   int ferr_base;
   logic [8:0] got_q[$];

   lcd_spi_rx #(
      .SYNC_STAGES (2),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_dc    (spi_dc),
      .spi_cs    (spi_cs),
      .rx_data   (rx_data),
      .rx_dc     (rx_dc),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .overflow  (overflow),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Records every accepted byte as {dc, data}, and counts frame_err cycles.
   always begin
      @(negedge clk);
      #2;
      if (rx_valid && rx_ready) begin
         got_q.push_back({rx_dc, rx_data});
      end
      if (frame_err) begin
         ferr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [8:0] exp);
      logic [15:0] o;
      if (got_q.size() == 0) begin
         o = 16'hFFFF;
      end else begin
         o = {7'b0, got_q.pop_front()};
      end
      check(tag, o, {7'b0, exp});
   endtask

   task automatic send_bit(input logic b, input logic dc);
      @(negedge clk);
      spi_clk  = 1'b0;
      spi_mosi = b;
      spi_dc   = dc;
      repeat (3) @(negedge clk);
      spi_clk = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] v, input logic dc, input int n);
      for (int i = 0; i < n; i++) begin
         send_bit(v[7-i], dc);
      end
   endtask

   task automatic cs_low();
      @(negedge clk);
      spi_clk = 1'b0;
      spi_cs  = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      @(negedge clk);
      spi_clk = 1'b0;
      repeat (3) @(negedge clk);
      spi_cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      spi_dc   = 1'b0;
      spi_cs   = 1'b1;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check("rst_valid", {15'b0, rx_valid}, 16'h0);
      check("rst_data", {8'b0, rx_data}, 16'h0);
      check("rst_flags", {12'b0, rx_dc, overflow, frame_err, busy}, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single byte 0xA5, DC=0, with exact latency from the 8th SCK rise.
      rx_ready = 1'b1;
      cs_low();
      #2;
      check("busy_in_frame", {15'b0, busy}, 16'h1);
      send_bits(8'hA5, 1'b0, 7);
      @(negedge clk);
      spi_clk  = 1'b0;
      spi_mosi = 1'b1;
      spi_dc   = 1'b0;
      repeat (3) @(negedge clk);
      spi_clk = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      check("lat_2clk_not_valid", {15'b0, rx_valid}, 16'h0);
      @(negedge clk);
      #2;
      check("lat_3clk_valid", {15'b0, rx_valid}, 16'h1);
      check("a5_data", {8'b0, rx_data}, 16'h00A5);
      check("a5_dc", {15'b0, rx_dc}, 16'h0);
      @(negedge clk);
      #2;
      check("a5_one_pulse", {15'b0, rx_valid}, 16'h0);
      cs_high();
      #2;
      check("busy_after_cs", {15'b0, busy}, 16'h0);
      check_pop("a5_popped", 9'h0A5);
      check("a5_only", 16'(got_q.size()), 16'h0);

      // Three bytes in one CS frame with DC 0,1,1.
      ferr_base = ferr_cnt;
      cs_low();
      send_bits(8'h2A, 1'b0, 8);
      send_bits(8'h00, 1'b1, 8);
      send_bits(8'h10, 1'b1, 8);
      cs_high();
      check_pop("multi_b0", 9'h02A);
      check_pop("multi_b1", 9'h100);
      check_pop("multi_b2", 9'h110);
      check("multi_no_ferr", 16'(ferr_cnt - ferr_base), 16'h0);

      // CS released after 5 bits: one frame_err cycle, nothing pushed.
      cs_low();
      send_bits(8'hFF, 1'b1, 5);
      cs_high();
      check("partial_ferr_pulse", 16'(ferr_cnt - ferr_base), 16'h1);
      check("partial_no_push", 16'(got_q.size()), 16'h0);
      check("partial_no_valid", {15'b0, rx_valid}, 16'h0);
      cs_low();
      send_bits(8'h3C, 1'b1, 8);
      cs_high();
      check_pop("after_err_3c", 9'h13C);
      check("after_err_ferr", 16'(ferr_cnt - ferr_base), 16'h1);

      // Full buffer with a push and a pop landing on the same cycle.
      rx_ready = 1'b0;
      cs_low();
      for (int v = 8'h11; v <= 8'h14; v++) begin
         send_bits(8'(v), 1'b1, 8);
      end
      repeat (4) @(negedge clk);
      #2;
      check("full_head", {7'b0, rx_valid, rx_data}, 16'h0111);
      send_bits(8'h15, 1'b1, 7);
      @(negedge clk);
      spi_clk  = 1'b0;
      spi_mosi = 1'b1;
      spi_dc   = 1'b1;
      repeat (3) @(negedge clk);
      spi_clk = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      #2;
      check("pushpop_no_ovf", {15'b0, overflow}, 16'h0);
      check("pushpop_head", {7'b0, rx_valid, rx_data}, 16'h0112);
      cs_high();
      rx_ready = 1'b1;
      repeat (10) @(negedge clk);
      rx_ready = 1'b0;
      #2;
      check_pop("pushpop_0", 9'h111);
      check_pop("pushpop_1", 9'h112);
      check_pop("pushpop_2", 9'h113);
      check_pop("pushpop_3", 9'h114);
      check_pop("pushpop_4", 9'h115);
      check("pushpop_count", 16'(got_q.size()), 16'h0);
      check("pushpop_ovf_final", {15'b0, overflow}, 16'h0);

      // Five bytes into a 4-deep buffer with no consumer.
      cs_low();
      for (int v = 1; v <= 5; v++) begin
         send_bits(8'(v), 1'b1, 8);
      end
      cs_high();
      #2;
      check("ovf_set", {15'b0, overflow}, 16'h1);
      check("ovf_head", {7'b0, rx_valid, rx_data}, 16'h0101);
      rx_ready = 1'b1;
      repeat (10) @(negedge clk);
      rx_ready = 1'b0;
      #2;
      check_pop("ovf_0", 9'h101);
      check_pop("ovf_1", 9'h102);
      check_pop("ovf_2", 9'h103);
      check_pop("ovf_3", 9'h104);
      check("ovf_dropped", 16'(got_q.size()), 16'h0);
      check("ovf_sticky", {15'b0, overflow}, 16'h1);
      check("ovf_empty_out", {7'b0, rx_valid, rx_data}, 16'h0);

      // Reset after 4 bits of a byte, then a fresh 0x81 frame.
      rx_ready = 1'b1;
      cs_low();
      send_bits(8'hF0, 1'b1, 4);
      @(negedge clk);
      rst     = 1'b1;
      spi_cs  = 1'b1;
      spi_clk = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("midrst_valid_data", {7'b0, rx_valid, rx_data}, 16'h0);
      check("midrst_flags", {12'b0, rx_dc, overflow, frame_err, busy}, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      ferr_base = ferr_cnt;
      cs_low();
      send_bits(8'h81, 1'b0, 8);
      cs_high();
      check_pop("post_rst_81", 9'h081);
      check("post_rst_only", 16'(got_q.size()), 16'h0);
      check("post_rst_no_ferr", 16'(ferr_cnt - ferr_base), 16'h0);
      check("post_rst_no_ovf", {15'b0, overflow}, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
